// File: rtl/dvp_tx_pkg.sv
// Shared types, default timing and the RGB444-to-DVP byte split for the DVP transmitter.
package dvp_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VSYNC,
    ST_VBACK,
    ST_ACTIVE,
    ST_VFRONT
  } state_t;

  localparam int DEF_H_ACTIVE    = 640;
  localparam int DEF_V_ACTIVE    = 480;
  localparam int DEF_H_BLANK     = 144;
  localparam int DEF_VSYNC_LINES = 3;
  localparam int DEF_V_BACK      = 17;
  localparam int DEF_V_FRONT     = 10;

  // First byte of a pixel carries R in the low nibble, second carries {G,B}.
  function automatic logic [7:0] rgb444_byte(input logic [11:0] px, input logic second);
    return second ? px[7:0] : {4'h0, px[11:8]};
  endfunction

endpackage

// File: rtl/dvp_tx_timing.sv
// Line/frame counters, frame FSM and sync/href/read-request strobes for dvp_tx.
module dvp_tx_timing
  import dvp_tx_pkg::*;
#(
  parameter int H_ACTIVE    = DEF_H_ACTIVE,
  parameter int V_ACTIVE    = DEF_V_ACTIVE,
  parameter int H_BLANK     = DEF_H_BLANK,
  parameter int VSYNC_LINES = DEF_VSYNC_LINES,
  parameter int V_BACK      = DEF_V_BACK,
  parameter int V_FRONT     = DEF_V_FRONT
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_enable,
  output logic o_vsync,
  output logic o_href,
  output logic o_sof,
  output logic o_req,
  output logic o_hsel
);

  localparam int LINE = 2 * H_ACTIVE + H_BLANK;
  localparam int HW   = $clog2(LINE);
  localparam int VW   = 16;

  state_t        r_state, w_state_nx;
  logic [HW-1:0] r_hcnt, w_hcnt_nx;
  logic [VW-1:0] r_vcnt, w_vcnt_nx, w_vlast;
  logic          w_eol, w_pre_line;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_hcnt  <= '0;
      r_vcnt  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_hcnt  <= w_hcnt_nx;
      r_vcnt  <= w_vcnt_nx;
    end
  end

  always_comb begin
    w_vlast = '0;
    case (r_state)
      ST_VSYNC:  w_vlast = VW'(VSYNC_LINES - 1);
      ST_VBACK:  w_vlast = VW'(V_BACK - 1);
      ST_ACTIVE: w_vlast = VW'(V_ACTIVE - 1);
      ST_VFRONT: w_vlast = VW'(V_FRONT - 1);
      default:   w_vlast = '0;
    endcase
  end

  assign w_eol = (r_hcnt == HW'(LINE - 1));

  always_comb begin
    w_state_nx = r_state;
    w_hcnt_nx  = r_hcnt;
    w_vcnt_nx  = r_vcnt;
    if (r_state == ST_IDLE) begin
      w_hcnt_nx = '0;
      w_vcnt_nx = '0;
      if (i_enable) w_state_nx = ST_VSYNC;
    end else begin
      w_hcnt_nx = w_eol ? '0 : r_hcnt + 1'b1;
      if (w_eol) begin
        if (r_vcnt == w_vlast) begin
          w_vcnt_nx = '0;
          case (r_state)
            ST_VSYNC:  w_state_nx = ST_VBACK;
            ST_VBACK:  w_state_nx = ST_ACTIVE;
            ST_ACTIVE: w_state_nx = ST_VFRONT;
            ST_VFRONT: w_state_nx = i_enable ? ST_VSYNC : ST_IDLE;
            default:   w_state_nx = ST_IDLE;
          endcase
        end else begin
          w_vcnt_nx = r_vcnt + 1'b1;
        end
      end
    end
  end

  // The next line carries pixels: prefetch pixel 0 two clocks before its end.
  assign w_pre_line = (r_state == ST_VBACK  && r_vcnt == VW'(V_BACK - 1)) ||
                      (r_state == ST_ACTIVE && r_vcnt != VW'(V_ACTIVE - 1));

  always_comb begin
    o_vsync = (r_state == ST_VSYNC);
    o_href  = (r_state == ST_ACTIVE) && (r_hcnt < HW'(2 * H_ACTIVE));
    o_sof   = (r_state == ST_VSYNC) && (r_vcnt == '0) && (r_hcnt == '0);
    o_req   = (w_pre_line && r_hcnt == HW'(LINE - 2)) ||
              (r_state == ST_ACTIVE && !r_hcnt[0] && r_hcnt < HW'(2 * H_ACTIVE - 2));
    o_hsel  = r_hcnt[0];
  end

endmodule

// File: rtl/dvp_tx.sv
// DVP transmitter: RGB444 pixels from a FIFO-like source sent as two bytes per pixel.
module dvp_tx
  import dvp_tx_pkg::*;
#(
  parameter int H_ACTIVE    = DEF_H_ACTIVE,
  parameter int V_ACTIVE    = DEF_V_ACTIVE,
  parameter int H_BLANK     = DEF_H_BLANK,
  parameter int VSYNC_LINES = DEF_VSYNC_LINES,
  parameter int V_BACK      = DEF_V_BACK,
  parameter int V_FRONT     = DEF_V_FRONT
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_enable,
  output logic        o_rd,
  input  logic [11:0] i_data,
  input  logic        i_empty,
  output logic        o_vsync,
  output logic        o_href,
  output logic [7:0]  o_data,
  output logic        o_sof,
  output logic        o_underrun
);

  logic        w_vsync, w_href, w_sof, w_req, w_hsel;
  logic        r_rd_d, r_req_d, r_underrun;
  logic [11:0] r_pix;

  dvp_tx_timing #(
    .H_ACTIVE    (H_ACTIVE),
    .V_ACTIVE    (V_ACTIVE),
    .H_BLANK     (H_BLANK),
    .VSYNC_LINES (VSYNC_LINES),
    .V_BACK      (V_BACK),
    .V_FRONT     (V_FRONT)
  ) u_timing (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_enable (i_enable),
    .o_vsync  (w_vsync),
    .o_href   (w_href),
    .o_sof    (w_sof),
    .o_req    (w_req),
    .o_hsel   (w_hsel)
  );

  // Gated by reset so an aborted frame never pulls one more pixel.
  assign o_rd = w_req & ~i_empty & ~i_rst;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_d     <= 1'b0;
      r_req_d    <= 1'b0;
      r_pix      <= '0;
      r_underrun <= 1'b0;
    end else begin
      r_rd_d  <= o_rd;
      r_req_d <= w_req;
      if (r_req_d) r_pix <= r_rd_d ? i_data : 12'h000;
      if (w_sof)                  r_underrun <= 1'b0;
      else if (w_req && i_empty)  r_underrun <= 1'b1;
    end
  end

  assign o_vsync    = w_vsync;
  assign o_href     = w_href;
  assign o_sof      = w_sof;
  assign o_data     = w_href ? rgb444_byte(r_pix, w_hsel) : 8'h00;
  assign o_underrun = r_underrun & ~w_sof;

endmodule

// File: tb/tb_dvp_tx.sv
// Self-checking bench for dvp_tx against a frame-position reference model.
module tb_dvp_tx;

  localparam int HA = 4, VA = 2, HB = 6, VS = 1, VB = 1, VF = 1;
  localparam int LINE  = 2 * HA + HB;
  localparam int FRAME = LINE * (VS + VB + VA + VF);
  localparam int NPIX  = HA * VA;

  logic        clk = 1'b0, rst = 1'b0, en = 1'b0, emp = 1'b0;
  logic [11:0] din = '0;
  logic        rd, vs, href, sof, und;
  logic [7:0]  dout;

  always #5 clk = ~clk;

  dvp_tx #(
    .H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB),
    .VSYNC_LINES(VS), .V_BACK(VB), .V_FRONT(VF)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_enable(en), .o_rd(rd), .i_data(din),
    .i_empty(emp), .o_vsync(vs), .o_href(href), .o_data(dout),
    .o_sof(sof), .o_underrun(und)
  );

  int tests = 0, fails = 0;
  int mpos = -1;
  logic [11:0] q[$];
  logic [11:0] cur = '0;
  bit mund = 1'b0;
  logic [11:0] pix_tab[64];
  int src_idx = 0, mdl_idx = 0;
  bit src_vld = 1'b0;
  logic [11:0] src_pix = '0;
  int vs_cnt = 0, rd_cnt = 0, u_cnt = 0, sof_cnt = 0, frames = 0;

  // Frame position p is the start (first byte) of some pixel.
  function automatic bit pix_start(int p);
    int ln, h;
    if (p < 0 || p >= FRAME) return 1'b0;
    ln = p / LINE;
    h  = p % LINE;
    return (ln >= VS + VB) && (ln < VS + VB + VA) && (h < 2 * HA) && (h % 2 == 0);
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s pos=%0d got=%0h exp=%0h", tag, mpos, got, exp);
    end
  endtask

  task automatic cyc(input bit e, input bit m, input bit r);
    bit e_sof, e_vs, e_href, e_req, e_rd, e_und;
    logic [7:0] e_data;
    int h, ln;
    en  = e;
    emp = m;
    rst = r;
    din = src_vld ? src_pix : 12'($urandom);
    #1;
    if (r) begin
      chk("rd_in_reset", 16'(rd), 16'(0));
      mpos = -1; q.delete(); cur = '0; mund = 1'b0;
      vs_cnt = 0; rd_cnt = 0; u_cnt = 0; src_vld = 1'b0;
    end else begin
      if (pix_start(mpos)) cur = (q.size() > 0) ? q.pop_front() : 12'hxxx;
      h  = (mpos < 0) ? 0 : mpos % LINE;
      ln = (mpos < 0) ? -1 : mpos / LINE;
      e_sof  = (mpos == 0);
      e_vs   = (mpos >= 0) && (mpos < VS * LINE);
      e_href = (ln >= VS + VB) && (ln < VS + VB + VA) && (h < 2 * HA);
      e_data = !e_href ? 8'h00 : (h % 2 == 0) ? {4'h0, cur[11:8]} : cur[7:0];
      e_req  = (mpos >= 0) && pix_start(mpos + 2);
      e_rd   = e_req && !m;
      e_und  = mund && !e_sof;
      chk("vsync", 16'(vs), 16'(e_vs));
      chk("href", 16'(href), 16'(e_href));
      chk("data", 16'(dout), 16'(e_data));
      chk("sof", 16'(sof), 16'(e_sof));
      chk("rd", 16'(rd), 16'(e_rd));
      chk("underrun", 16'(und), 16'(e_und));
      if (sof) sof_cnt++;
      if (vs) vs_cnt++;
      if (rd) rd_cnt++;
      if (e_sof) mund = 1'b0;
      if (e_req) begin
        if (m) begin
          q.push_back(12'h000); mund = 1'b1; u_cnt++;
        end else begin
          q.push_back(pix_tab[mdl_idx % 64]); mdl_idx++;
        end
      end
      src_vld = rd;
      if (rd) begin
        src_pix = pix_tab[src_idx % 64];
        src_idx++;
      end
      if (mpos < 0) begin
        if (e) mpos = 0;
      end else begin
        mpos++;
        if (mpos == FRAME) begin
          chk("vs_per_frame", 16'(vs_cnt), 16'(VS * LINE));
          chk("rd_per_frame", 16'(rd_cnt + u_cnt), 16'(NPIX));
          frames++;
          vs_cnt = 0; rd_cnt = 0; u_cnt = 0;
          mpos = e ? 0 : -1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int s0;
    for (int i = 0; i < 64; i++) pix_tab[i] = 12'($urandom);
    pix_tab[0] = 12'hABC;
    pix_tab[1] = 12'h123;
    @(posedge clk);
    #1;

    // Reset state
    cyc(0, 0, 1);
    cyc(0, 0, 1);
    chk("rst_vsync", 16'(vs), 16'(0));
    chk("rst_href", 16'(href), 16'(0));
    chk("rst_data", 16'(dout), 16'(0));
    chk("rst_sof", 16'(sof), 16'(0));
    chk("rst_underrun", 16'(und), 16'(0));
    repeat (3) cyc(0, 0, 0);

    // Two back-to-back frames; second one starves pixel 2 of its first active line
    for (int k = 0; k < 2 * FRAME + 1; k++)
      cyc(1, frames == 1 && mpos == (VS + VB) * LINE + 2 * 2 - 2, 0);
    chk("frames_after_b2b", 16'(frames), 16'(2));

    // Drop enable at frame clock 20: frame must finish, then no new sof
    for (int k = 0; k < 2 * FRAME && mpos != 20; k++) cyc(1, 0, 0);
    s0 = sof_cnt;
    repeat (FRAME + 10) cyc(0, 0, 0);
    chk("no_sof_after_disable", 16'(sof_cnt - s0), 16'(0));
    chk("frames_after_disable", 16'(frames), 16'(3));

    // Random empties over a full frame
    for (int k = 0; k < FRAME + 1; k++) cyc(1, $urandom_range(0, 3) == 0, 0);

    // Reset at frame clock 35 (ACTIVE), then re-enable
    for (int k = 0; k < 2 * FRAME && mpos != 35; k++) cyc(1, 0, 0);
    cyc(1, 0, 1);
    s0 = sof_cnt;
    cyc(0, 0, 0);
    for (int k = 0; k < FRAME + 2; k++) cyc(1, 0, 0);
    chk("sof_after_reset", 16'(sof_cnt - s0), 16'(2));
    repeat (FRAME) cyc(0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
